// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op encoding, FSM states and
// op classification helpers.
package mem_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLoadResp = 2'd1,
        StRmwWrite = 2'd2
    } state_e;

    function automatic logic is_store(input logic [2:0] op);
        return op >= OP_SW;
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_byte(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic is_word(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane handling: extracts and extends sub-word loads, and merges store data
// into a read word for sub-word read-modify-write.
module lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{byte_off, 3'b000} +: 8];
        half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];

        unique case (op)
            OP_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_data = {16'h0000, half_lane};
            OP_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  load_data = {24'h000000, byte_lane};
            default: load_data = rdata;
        endcase

        // Untouched lanes pass through bit-exact from the read word.
        merge_data = rdata;
        unique case (op)
            OP_SW: merge_data = wdata;
            OP_SH: begin
                if (byte_off[1]) merge_data[31:16] = wdata[15:0];
                else             merge_data[15:0]  = wdata[15:0];
            end
            OP_SB:   merge_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
            default: merge_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: maps byte/half/word loads and stores onto a word-only,
// synchronous-read data memory, stalling the pipeline for reads and read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        req_fault;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    lane_align u_lane_align (
        .op         (op_q),
        .byte_off   (addr_q[1:0]),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        req_fault = (is_half(req_op) && req_addr[0])
                 || (is_word(req_op) && (req_addr[1:0] != 2'b00))
                 || (req_addr >= MEM_BYTES);
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        fault      = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_fault) begin
                        fault      = 1'b1;
                        resp_valid = 1'b1;
                    end else begin
                        op_d     = req_op;
                        addr_d   = req_addr;
                        wdata_d  = req_wdata;
                        mem_addr = {req_addr[31:2], 2'b00};
                        if (req_op == OP_SW) begin
                            mem_write  = 1'b1;
                            mem_wdata  = req_wdata;
                            resp_valid = 1'b1;
                        end else begin
                            // Loads and sub-word stores both start with a word read.
                            mem_read = 1'b1;
                            stall    = 1'b1;
                            state_d  = is_store(req_op) ? StRmwWrite : StLoadResp;
                        end
                    end
                end
            end
            StLoadResp: begin
                mem_addr   = {addr_q[31:2], 2'b00};
                resp_valid = 1'b1;
                resp_rdata = load_data;
                state_d    = StIdle;
            end
            StRmwWrite: begin
                mem_addr   = {addr_q[31:2], 2'b00};
                mem_write  = 1'b1;
                mem_wdata  = merge_data;
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random traffic checked against a
// word-array memory model with arithmetic lane extraction and merging.
module tb_mem_access_unit;

    localparam int unsigned MemBytes = 1024;
    localparam int unsigned Words    = MemBytes / 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall, resp_valid, fault, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] mem       [Words];
    logic [31:0] model_mem [Words];
    logic        clear_mem;
    logic        watch_wr;
    logic        wr_seen;
    bit          stall_log [$];

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(MemBytes)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .fault      (fault),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    // Word-only, synchronous-read data memory.
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < Words; i++) mem[i] <= 32'h0;
        end else begin
            if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
            if (mem_read)  mem_rdata <= mem[mem_addr[9:2]];
        end
        if (watch_wr && mem_write) wr_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] w;
        int unsigned v;
        w = model_mem[addr[9:2]];
        case (op)
            3'd1, 3'd2: begin
                v = (w >> (16 * int'(addr[1]))) & 32'hFFFF;
                if (op == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
            end
            3'd3, 3'd4: begin
                v = (w >> (8 * int'(addr[1:0]))) & 32'hFF;
                if (op == 3'd3 && v >= 32'h80) v = v + 32'hFFFFFF00;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_store(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] wd);
        logic [31:0] w, mask;
        int unsigned sh;
        w = model_mem[addr[9:2]];
        if (op == 3'd6) begin
            sh   = 16 * int'(addr[1]);
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((wd & 32'hFFFF) << sh);
        end else if (op == 3'd7) begin
            sh   = 8 * int'(addr[1:0]);
            mask = 32'hFF << sh;
            return (w & ~mask) | ((wd & 32'hFF) << sh);
        end
        return wd;
    endfunction

    // One request held for exactly its own cycles; all outputs checked every cycle.
    task automatic run_req(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd);
        logic        flt;
        logic [31:0] waddr;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        waddr = addr & 32'hFFFF_FFFC;
        flt = ((op == 3'd1 || op == 3'd2 || op == 3'd6) && addr[0])
           || ((op == 3'd0 || op == 3'd5) && addr[1:0] != 2'b00)
           || (addr >= MemBytes);
        stall_log.push_back(stall);
        if (flt) begin
            check("flt_fault", {31'b0, fault}, 32'd1);
            check("flt_resp_valid", {31'b0, resp_valid}, 32'd1);
            check("flt_stall", {31'b0, stall}, 32'd0);
            check("flt_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
            check("flt_rdata", resp_rdata, 32'd0);
        end else if (op == 3'd5) begin
            check("sw_ctrl", {27'b0, stall, resp_valid, fault, mem_read, mem_write},
                  32'b01001);
            check("sw_addr", mem_addr, waddr);
            check("sw_wdata", mem_wdata, wd);
            check("sw_rdata", resp_rdata, 32'd0);
            model_mem[addr[9:2]] = wd;
        end else begin
            check("rd_ctrl", {27'b0, stall, resp_valid, fault, mem_read, mem_write},
                  32'b10010);
            check("rd_addr", mem_addr, waddr);
            @(negedge clk);
            #1;
            stall_log.push_back(stall);
            if (op >= 3'd5) begin
                check("rmw_ctrl", {27'b0, stall, resp_valid, fault, mem_read, mem_write},
                      32'b01001);
                check("rmw_addr", mem_addr, waddr);
                check("rmw_wdata", mem_wdata, exp_store(op, addr, wd));
                check("rmw_rdata", resp_rdata, 32'd0);
                model_mem[addr[9:2]] = exp_store(op, addr, wd);
            end else begin
                check("ld_ctrl", {27'b0, stall, resp_valid, fault, mem_read, mem_write},
                      32'b01000);
                check("ld_rdata", resp_rdata, exp_load(op, addr));
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("idle_outputs", {27'b0, stall, resp_valid, fault, mem_read, mem_write}, 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        logic [4:0]  pat;
        int          bad;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        clear_mem = 1'b1;
        watch_wr  = 1'b0;
        wr_seen   = 1'b0;
        for (int i = 0; i < Words; i++) model_mem[i] = 32'h0;
        @(negedge clk);
        #1;
        check("rst_outputs", {27'b0, stall, resp_valid, fault, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        clear_mem = 1'b0;
        reset     = 1'b0;

        // Directed word/half/byte sequence on word 0x10.
        run_req(3'd5, 32'h10, 32'h1122_3344);
        run_req(3'd0, 32'h10, 32'h0);
        check("lw_value", resp_rdata, 32'h1122_3344);
        run_req(3'd7, 32'h11, 32'h0000_00AA);
        run_req(3'd3, 32'h11, 32'h0);
        check("lb_value", resp_rdata, 32'hFFFF_FFAA);
        run_req(3'd4, 32'h11, 32'h0);
        check("lbu_value", resp_rdata, 32'h0000_00AA);
        run_req(3'd6, 32'h12, 32'h0000_8001);
        idle_cycle();
        check("mem_word_10", mem[4], 32'h8001_AA44);
        run_req(3'd1, 32'h12, 32'h0);
        check("lh_value", resp_rdata, 32'hFFFF_8001);
        run_req(3'd2, 32'h12, 32'h0);
        check("lhu_value", resp_rdata, 32'h0000_8001);

        // Faults.
        run_req(3'd0, 32'h13, 32'h0);
        run_req(3'd1, 32'h11, 32'h0);
        run_req(3'd5, 32'h400, 32'hDEAD_BEEF);
        idle_cycle();
        check("fault_mem_word_10", mem[4], 32'h8001_AA44);

        // Reset while an SB sits in its write cycle.
        run_req(3'd5, 32'h30, 32'hCAFE_BABE);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd7;
        req_addr  = 32'h31;
        req_wdata = 32'h55;
        watch_wr  = 1'b1;
        wr_seen   = 1'b0;
        #1;
        check("rst_sb_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("rst_mid_outputs", {27'b0, stall, resp_valid, fault, mem_read, mem_write},
              32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_cycle();
        watch_wr = 1'b0;
        check("rst_no_write", {31'b0, wr_seen}, 32'd0);
        check("rst_word_kept", mem[12], 32'hCAFE_BABE);

        // Back-to-back: SB, LB, SW with no idle gaps.
        run_req(3'd5, 32'h20, 32'h7766_5544);
        idle_cycle();
        stall_log.delete();
        run_req(3'd7, 32'h20, 32'h0000_0099);
        run_req(3'd3, 32'h21, 32'h0);
        check("b2b_lb", resp_rdata, 32'h0000_0055);
        run_req(3'd5, 32'h24, 32'h0BAD_F00D);
        check("b2b_cycles", stall_log.size(), 32'd5);
        pat = 5'b0;
        foreach (stall_log[i]) pat = {pat[3:0], stall_log[i]};
        check("b2b_stall_pattern", {27'b0, pat}, 32'b10100);
        idle_cycle();
        check("b2b_word_20", mem[8], 32'h7766_5599);
        check("b2b_word_24", mem[9], 32'h0BAD_F00D);

        // Random traffic over a small window, with occasional out-of-range addresses.
        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) addr = $urandom_range(MemBytes, MemBytes + 4096);
            else if ($urandom_range(0, 19) == 0) addr = $urandom;
            else addr = $urandom_range(0, 8'hFF);
            run_req(op, addr, $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        bad = 0;
        for (int i = 0; i < Words; i++) if (mem[i] !== model_mem[i]) bad++;
        check("final_mem_mismatch_words", bad, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
